// File: rtl/prv32_divider.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; b==0 and signed overflow bypass the iteration.
module prv32_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] r
);

  // state | meaning
  // IDLE  | waiting for start; also the cycle where done is shown
  // CALC  | shifting out one quotient bit per cycle
  // FIN   | sign fix-up, result loaded into r at the closing edge
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam int CW = $clog2(XLEN);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvd, dsr, rem;
  logic [1:0]      op_q;
  logic            neg_q, neg_r;

  logic            accept, is_signed, b_zero, ovf, done_set;
  logic [XLEN-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [XLEN:0]   rem_sh, diff;

  assign accept    = start && !busy && !flush;
  assign is_signed = !op[0];
  assign b_zero    = (b == '0);
  assign ovf       = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign a_mag     = (is_signed && a[XLEN-1]) ? -a : a;
  assign b_mag     = (is_signed && b[XLEN-1]) ? -b : b;

  // The partial remainder can reach XLEN bits before the shift, so the
  // compare/subtract is done XLEN+1 wide and the borrow decides the q bit.
  assign rem_sh = {rem, dvd[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dsr};

  assign q_fix = (!op_q[0] && neg_q) ? -dvd : dvd;
  assign r_fix = (!op_q[0] && neg_r) ? -rem : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = (b_zero || ovf) ? FIN : CALC;
      CALC: begin
        if (flush)           state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = FIN;
      end
      FIN: begin
        state_nxt = IDLE;
        done_set  = !flush;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      r     <= '0;
      cnt   <= '0;
      dvd   <= '0;
      dsr   <= '0;
      rem   <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done <= done_set;
      if (flush || done) busy <= 1'b0;
      else if (accept)   busy <= 1'b1;

      if (state == IDLE && accept) begin
        op_q <= op;
        cnt  <= CW'(XLEN-1);
        dsr  <= b_mag;
        // Special cases preload quotient/remainder so FIN needs no extra path.
        if (b_zero) begin
          dvd   <= '1;
          rem   <= a;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else if (ovf) begin
          dvd   <= a;
          rem   <= '0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else begin
          dvd   <= a_mag;
          rem   <= '0;
          neg_q <= is_signed && (a[XLEN-1] ^ b[XLEN-1]);
          neg_r <= is_signed && a[XLEN-1];
        end
      end

      if (state == CALC) begin
        dvd <= {dvd[XLEN-2:0], ~diff[XLEN]};
        rem <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        cnt <= cnt - 1'b1;
      end

      if (done_set) r <= op_q[1] ? r_fix : q_fix;
    end
  end

endmodule
